// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between the IF and MEM
// pipeline stages, with per-stage stall generation.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_valid,
  output logic                mem_stall,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          gnt
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                last_mem;
  logic [1:0]          gnt_q;
  logic                take_if, take_mem, done;
  logic                cmd_we;
  logic [DATA_W/8-1:0] cmd_be;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  assign done = (state == WAIT) && (cnt == LAST_CNT);

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_if   = 1'b0;
    take_mem  = 1'b0;
    unique case (state)
      IDLE: begin
        // MEM has priority, but yields to IF when it also won the last grant.
        if (mem_req && (!if_req || !last_mem)) take_mem = 1'b1;
        else if (if_req)                       take_if  = 1'b1;
        if (take_mem || take_if) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (cnt == LAST_CNT) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_mem  <= 1'b0;
      gnt_q     <= 2'b00;
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take_mem) begin
        last_mem  <= 1'b1;
        gnt_q     <= 2'b10;
        cmd_we    <= mem_we;
        cmd_be    <= mem_be;
        cmd_addr  <= mem_addr;
        cmd_wdata <= mem_wdata;
      end else if (take_if) begin
        last_mem  <= 1'b0;
        gnt_q     <= 2'b01;
        cmd_we    <= 1'b0;
        cmd_be    <= '1;
        cmd_addr  <= if_addr;
        cmd_wdata <= '0;
      end else if (done) begin
        gnt_q <= 2'b00;
      end
    end
  end

  assign m_en    = (state == ISSUE);
  assign m_we    = m_en & cmd_we;
  assign m_be    = cmd_be;
  assign m_addr  = cmd_addr;
  assign m_wdata = cmd_wdata;
  assign gnt     = gnt_q;

  assign if_valid  = done & gnt_q[0];
  assign mem_valid = done & gnt_q[1];
  assign if_rdata  = if_valid ? m_rdata : '0;
  // A write completion returns no data even though the memory drives the bus.
  assign mem_rdata = (mem_valid && !cmd_we) ? m_rdata : '0;
  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: three arbiter lanes with MEM_LAT 2, 1 and 15, each with
// its own fixed-latency memory model, checked through a completion scoreboard.
module tb_unified_mem_arbiter;

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic [31:0] if_rdata  [3];
  logic        if_valid  [3];
  logic        if_stall  [3];
  logic        mem_req   [3];
  logic        mem_we    [3];
  logic [3:0]  mem_be    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        mem_valid [3];
  logic        mem_stall [3];
  logic        m_en      [3];
  logic        m_we      [3];
  logic [3:0]  m_be      [3];
  logic [31:0] m_addr    [3];
  logic [31:0] m_wdata   [3];
  logic [31:0] m_rdata   [3];
  logic [1:0]  gnt       [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    logic [31:0] pipe [16];

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(k))) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_rdata(if_rdata[k]),
      .if_valid(if_valid[k]), .if_stall(if_stall[k]),
      .mem_req(mem_req[k]), .mem_we(mem_we[k]), .mem_be(mem_be[k]),
      .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]),
      .mem_valid(mem_valid[k]), .mem_stall(mem_stall[k]),
      .m_en(m_en[k]), .m_we(m_we[k]), .m_be(m_be[k]), .m_addr(m_addr[k]),
      .m_wdata(m_wdata[k]), .m_rdata(m_rdata[k]), .gnt(gnt[k])
    );

    // Data appears exactly MEM_LAT cycles after m_en; garbage otherwise.
    always_ff @(posedge clk) begin
      pipe[0] <= m_en[k] ? mem_func(m_addr[k]) : 32'hBAD0_0BAD;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[k] = pipe[lat_of(k)-1];
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_check(input int l);
    exp_t        e;
    logic [31:0] obs;
    checks += 2;
    if (!if_valid[l] && if_rdata[l] !== 32'h0) begin
      errors++; $display("FAIL if_rdata_idle lane%0d cyc%0d: got %h want 0", l, cyc, if_rdata[l]);
    end
    if (!mem_valid[l] && mem_rdata[l] !== 32'h0) begin
      errors++; $display("FAIL mem_rdata_idle lane%0d cyc%0d: got %h want 0", l, cyc, mem_rdata[l]);
    end
    if (if_valid[l] === 1'b1 || mem_valid[l] === 1'b1) begin
      checks++;
      obs = mem_valid[l] ? mem_rdata[l] : if_rdata[l];
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_valid lane%0d cyc%0d: if=%b mem=%b", l, cyc, if_valid[l], mem_valid[l]);
      end else begin
        e = exp_q.pop_front();
        if (if_valid[l] !== !e.is_mem || mem_valid[l] !== e.is_mem || obs !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL completion lane%0d: got if=%b mem=%b data=%h cyc=%0d want mem=%b data=%h cyc=%0d",
                   l, if_valid[l], mem_valid[l], obs, cyc, e.is_mem, e.data, e.due);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      checks++; errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_valid lane%0d cyc%0d: no completion observed, want mem=%b at cyc %0d", l, cyc, e.is_mem, e.due);
    end
  endtask

  task automatic drain_check(input int l);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain lane%0d: %0d completions outstanding, want 0", l, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b1; if_addr[k] = 32'h100;
      mem_req[k] = 1'b1; mem_we[k] = 1'b1; mem_be[k] = 4'hF;
      mem_addr[k] = 32'h300; mem_wdata[k] = 32'hFFFF_FFFF;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (m_en[k] !== 1'b0 || m_we[k] !== 1'b0 || if_valid[k] !== 1'b0 || mem_valid[k] !== 1'b0 ||
            if_rdata[k] !== 32'h0 || mem_rdata[k] !== 32'h0 || gnt[k] !== 2'b00) begin
          errors++;
          $display("FAIL reset lane%0d: m_en=%b m_we=%b iv=%b mv=%b ird=%h mrd=%h gnt=%b want all 0",
                   k, m_en[k], m_we[k], if_valid[k], mem_valid[k], if_rdata[k], mem_rdata[k], gnt[k]);
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; mem_req[k] = 1'b0; mem_we[k] = 1'b0;
    end
  endtask

  task automatic test_lone_if(input int l);
    int L = lat_of(l);
    int t0 = 0;
    for (int k = 0; k <= L + 3; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc; if_req[l] = 1'b1; if_addr[l] = 32'h100;
        exp_q.push_back(exp_t'{1'b0, 32'hDEAD_BEEF, t0 + 1 + L});
      end
      if (k == L + 2) if_req[l] = 1'b0;
      #1;
      checks += 2;
      if (m_en[l] !== (k == 1)) begin
        errors++; $display("FAIL lone_if_m_en lane%0d k%0d: got %b want %b", l, k, m_en[l], k == 1);
      end
      if (if_stall[l] !== (k <= L)) begin
        errors++; $display("FAIL lone_if_stall lane%0d k%0d: got %b want %b", l, k, if_stall[l], k <= L);
      end
      if (k == 1) begin
        checks++;
        if (m_addr[l] !== 32'h100 || m_we[l] !== 1'b0 || m_be[l] !== 4'hF || m_wdata[l] !== 32'h0) begin
          errors++;
          $display("FAIL lone_if_cmd lane%0d: addr=%h we=%b be=%h wd=%h want 100/0/f/0",
                   l, m_addr[l], m_we[l], m_be[l], m_wdata[l]);
        end
      end
      tick_check(l);
    end
    drain_check(l);
  endtask

  task automatic test_contention(input int l);
    int         L = lat_of(l);
    int         t0 = 0;
    logic [1:0] g_exp;
    for (int k = 0; k <= 2 * L + 5; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc;
        if_req[l] = 1'b1; if_addr[l] = 32'h200;
        mem_req[l] = 1'b1; mem_we[l] = 1'b0; mem_be[l] = 4'hF; mem_addr[l] = 32'h300;
        exp_q.push_back(exp_t'{1'b1, mem_func(32'h300), t0 + 1 + L});
        exp_q.push_back(exp_t'{1'b0, mem_func(32'h200), t0 + 2 * L + 3});
      end
      if (k == L + 2) mem_req[l] = 1'b0;
      if (k == 2 * L + 4) if_req[l] = 1'b0;
      #1;
      g_exp = (k >= 1 && k <= L + 1) ? 2'b10 : (k >= L + 3 && k <= 2 * L + 3) ? 2'b01 : 2'b00;
      checks += 4;
      if (m_en[l] !== (k == 1 || k == L + 3)) begin
        errors++; $display("FAIL contention_m_en lane%0d k%0d: got %b", l, k, m_en[l]);
      end
      if (gnt[l] !== g_exp) begin
        errors++; $display("FAIL contention_gnt lane%0d k%0d: got %b want %b", l, k, gnt[l], g_exp);
      end
      if (if_stall[l] !== (k <= 2 * L + 2)) begin
        errors++; $display("FAIL contention_if_stall lane%0d k%0d: got %b want %b", l, k, if_stall[l], k <= 2 * L + 2);
      end
      if (mem_stall[l] !== (k <= L)) begin
        errors++; $display("FAIL contention_mem_stall lane%0d k%0d: got %b want %b", l, k, mem_stall[l], k <= L);
      end
      if (k == 1 || k == L + 3) begin
        checks++;
        if (m_addr[l] !== ((k == 1) ? 32'h300 : 32'h200)) begin
          errors++; $display("FAIL contention_addr lane%0d k%0d: got %h", l, k, m_addr[l]);
        end
      end
      tick_check(l);
    end
    drain_check(l);
  endtask

  task automatic test_alternation(input int l);
    int         L = lat_of(l);
    int         n = lat_of(l) + 2;
    int         t0 = 0;
    logic       who;
    logic [1:0] g_exp;
    for (int k = 0; k <= 5 * n + 1; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc;
        if_req[l] = 1'b1; if_addr[l] = 32'h10;
        mem_req[l] = 1'b1; mem_we[l] = 1'b0; mem_addr[l] = 32'h20;
        for (int i = 0; i < 5; i++) begin
          who = (i % 2 == 0);
          exp_q.push_back(exp_t'{who, mem_func(who ? 32'h20 : 32'h10), t0 + (i + 1) * n - 1});
        end
      end
      if (k == 5 * n) begin
        if_req[l] = 1'b0; mem_req[l] = 1'b0;
      end
      #1;
      if (k % n == 1 && k < 5 * n) begin
        g_exp = ((k / n) % 2 == 0) ? 2'b10 : 2'b01;
        checks++;
        if (gnt[l] !== g_exp || m_en[l] !== 1'b1 || m_addr[l] !== (g_exp[1] ? 32'h20 : 32'h10)) begin
          errors++;
          $display("FAIL alternation lane%0d L%0d k%0d: gnt=%b m_en=%b addr=%h want gnt=%b", l, L, k,
                   gnt[l], m_en[l], m_addr[l], g_exp);
        end
      end
      tick_check(l);
    end
    drain_check(l);
  endtask

  task automatic test_write(input int l);
    int L = lat_of(l);
    int t0 = 0;
    for (int k = 0; k <= L + 3; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc;
        mem_req[l] = 1'b1; mem_we[l] = 1'b1; mem_be[l] = 4'b0011;
        mem_addr[l] = 32'h40; mem_wdata[l] = 32'h1234_5678;
        exp_q.push_back(exp_t'{1'b1, 32'h0, t0 + 1 + L});
      end
      if (k == L + 2) begin
        mem_req[l] = 1'b0; mem_we[l] = 1'b0;
      end
      #1;
      checks++;
      if (m_en[l] !== (k == 1) || m_we[l] !== (k == 1)) begin
        errors++; $display("FAIL write_strobe lane%0d k%0d: m_en=%b m_we=%b", l, k, m_en[l], m_we[l]);
      end
      if (k == 1) begin
        checks++;
        if (m_be[l] !== 4'b0011 || m_addr[l] !== 32'h40 || m_wdata[l] !== 32'h1234_5678) begin
          errors++;
          $display("FAIL write_cmd lane%0d: be=%b addr=%h wd=%h want 0011/40/12345678",
                   l, m_be[l], m_addr[l], m_wdata[l]);
        end
      end
      tick_check(l);
    end
    drain_check(l);
  endtask

  task automatic test_reset_wait(input int l);
    int L  = lat_of(l);
    int rc = (lat_of(l) >= 2) ? 2 : 1;
    int t0 = 0;
    for (int k = 0; k <= rc + L + 6; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc; if_req[l] = 1'b1; if_addr[l] = 32'h100;
      end
      if (k == rc) begin
        rst = 1'b1; if_req[l] = 1'b0;
      end
      if (k == rc + 1) rst = 1'b0;
      if (k == rc + 3) begin
        mem_req[l] = 1'b1; mem_we[l] = 1'b0; mem_addr[l] = 32'h300;
        exp_q.push_back(exp_t'{1'b1, mem_func(32'h300), t0 + rc + 4 + L});
      end
      if (k == rc + 5 + L) mem_req[l] = 1'b0;
      #1;
      if (k == rc + 1) begin
        checks++;
        if (if_valid[l] !== 1'b0 || gnt[l] !== 2'b00 || m_en[l] !== 1'b0 || m_we[l] !== 1'b0 ||
            m_be[l] !== 4'h0 || m_addr[l] !== 32'h0 || m_wdata[l] !== 32'h0) begin
          errors++;
          $display("FAIL reset_wait lane%0d: iv=%b gnt=%b m_en=%b be=%h addr=%h want all 0",
                   l, if_valid[l], gnt[l], m_en[l], m_be[l], m_addr[l]);
        end
      end
      tick_check(l);
    end
    drain_check(l);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; mem_req[k] = 1'b0; mem_we[k] = 1'b0;
      mem_be[k] = '0; mem_addr[k] = '0; mem_wdata[k] = '0;
    end
    test_reset();
    for (int l = 0; l < 3; l++) begin
      test_lone_if(l);
      test_contention(l);
      test_alternation(l);
      test_write(l);
      test_reset_wait(l);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares a single-port unified instruction/data memory between the IF stage and the MEM stage of the 5-stage pipeline CPU. It sits between the two pipeline stages and the memory macro. It grants one access at a time and sequences the fixed-latency memory command. It also generates the per-stage stall signals that freeze the pipeline while an access is outstanding or waiting.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; must be a multiple of 8
MEM_LAT, 2, cycles from the m_en cycle to the cycle m_rdata is valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  IF-stage read request; held with if_addr until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, meaningful only while if_valid
if_valid  out  1  one-cycle completion pulse for IF
if_stall  out  1  IF must hold; combinational if_req & ~if_valid
mem_req  in  1  MEM-stage request; held with all mem_* inputs until mem_valid
mem_we  in  1  1 = write, 0 = read
mem_be  in  DATA_W/8  write byte enables
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  write data
mem_rdata  out  DATA_W  load data, meaningful only while mem_valid
mem_valid  out  1  one-cycle completion pulse for MEM
mem_stall  out  1  combinational mem_req & ~mem_valid
m_en  out  1  memory command strobe, one cycle per access
m_we  out  1  memory write enable
m_be  out  DATA_W/8  memory byte enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en
gnt  out  2  debug: 2'b01 IF owns memory, 2'b10 MEM owns, 2'b00 idle

Behaviour:
- FSM states:
  - IDLE: sample requests.
  - ISSUE: m_en=1 for exactly one cycle; the m_* command is driven from registers.
  - WAIT: counter runs MEM_LAT-1 cycles, then the completion cycle.
  - Next state after completion is always IDLE.
- Grant is decided only in IDLE, at the rising edge:
  - Only one request pending: that requester wins.
  - Both pending: MEM wins, unless the previous grant was MEM. In that case IF wins, so strict alternation applies under contention.
  - last_gnt resets to IF.
- Timeline for a request sampled at edge E, ending cycle c:
  - m_en is high in cycle c+1.
  - Completion is cycle c+1+MEM_LAT. In that cycle the winner's *_valid=1 and *_rdata = m_rdata.
  - For a write, mem_rdata = 0.
  - The FSM is back in IDLE in cycle c+2+MEM_LAT.
  - One access therefore occupies MEM_LAT+2 cycles including the IDLE sample cycle.
- No grant is taken in the completion cycle. This guarantees a requester that drops req at the edge after *_valid is never re-issued.
- Command registers capture the winner's inputs at the grant edge and hold them stable until IDLE. For IF grants: m_we=0, m_be=all ones, m_wdata=0.
- Outputs outside the ISSUE cycle: m_en=0, m_we=0. m_addr/m_be/m_wdata hold their last value.
- Reset (rst=1 at a rising edge), from any state including ISSUE/WAIT:
  - FSM goes to IDLE, counter=0, last_gnt=IF.
  - m_en, m_we, m_be, m_addr, m_wdata, if_valid, mem_valid, if_rdata, mem_rdata and gnt are all 0 in the following cycle.
  - The in-flight access is abandoned: no valid pulse. Memory data returning later is ignored.
- A request withdrawn before it is granted has no effect. Withdrawing a request after it is granted is illegal; the arbiter completes the access anyway.
- *_rdata outputs are 0 whenever the matching *_valid is 0.
- Counter width is 4 bits. MEM_LAT=1 gives WAIT zero extra cycles: completion is the cycle after ISSUE.

Test Plan:
1. Reset: rst=1 for 3 cycles with both reqs high -> m_en, m_we, both valids, both rdata and gnt all 0; no m_en pulse while rst=1.
2. Lone IF read, MEM_LAT=2, memory model returns 0xDEAD_BEEF for 0x100; if_req in cycle 0 -> m_en cycle 1 with m_addr=0x100, if_valid cycle 3 with if_rdata=0xDEAD_BEEF; if_stall=1 in cycles 0-2 and 0 in cycle 3.
3. Simultaneous IF(0x200) and MEM read(0x300) in cycle 0 -> MEM served first (mem_valid cycle 3), IF granted at the end of cycle 4 (m_en cycle 5, if_valid cycle 7); if_stall high in cycles 0-6.
4. Both reqs held permanently for 5 accesses -> gnt sequence MEM, IF, MEM, IF, MEM; neither side waits more than one access.
5. MEM write: addr 0x40, wdata 0x1234_5678, be 4'b0011 -> m_en with m_we=1, m_be=0011, m_wdata=0x1234_5678; mem_valid MEM_LAT cycles later with mem_rdata=0.
6. rst pulsed in the WAIT cycle of an IF access -> no if_valid, gnt=0 next cycle; a new MEM request afterwards completes with correct data. Repeat tests 2-3 with MEM_LAT=1 and MEM_LAT=15.
